load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port in the Risky core. It accepts load/store requests from the execute stage and drives the word-addressed, one-cycle-read-latency data memory. It adds byte and halfword accesses with sign/zero extension on loads, and uses read-modify-write for sub-word stores because the memory has no byte enables. It also flags misaligned accesses without touching memory.

## Interface
Parameters:
- ADDRESS_SIZE, `ADDRESS_SIZE, width of the memory word address; the request byte address is ADDRESS_SIZE+2 bits
- DATA_SIZE, `DATA_SIZE (32), data word width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  high only in IDLE and while reset is low
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0
- req_address  in  ADDRESS_SIZE+2  byte address
- req_data  in  DATA_SIZE  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse, no backpressure
- resp_error  out  1  misaligned or illegal size; qualified by resp_valid
- resp_data  out  DATA_SIZE  load result; 0 for stores, errors, and when resp_valid is low
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDRESS_SIZE  word index = req_address[ADDRESS_SIZE+1:2]
- mem_data_out  out  DATA_SIZE  write data to memory
- mem_data_in  in  DATA_SIZE  memory read data, valid the cycle after mem_read

## Operation
- A request is captured (address, size, write, unsigned, data) on the edge where req_valid && req_ready.
- Byte lanes are little-endian:
  - Byte lane is addr[1:0], bits [8*off+7 : 8*off].
  - Half lane is addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Misaligned cases: half with addr[0]=1, word with addr[1:0]!=0, or size 11.
- FSM states: IDLE, READ, MERGE, WRITE, ERROR. mem_read and mem_write are never asserted together.
- IDLE: req_ready=1. On accept, the next state is:
  - ERROR if misaligned;
  - WRITE for a word store;
  - READ otherwise.
- READ: mem_read=1 and mem_address driven → MERGE.
- MERGE: samples mem_data_in.
  - Load: resp_valid=1, resp_data = selected lane sign/zero-extended (word passes through) → IDLE.
  - Sub-word store: merged word is latched (selected lane replaced by req_data low bits, other lanes preserved) → WRITE.
- WRITE: mem_write=1, mem_address driven, mem_data_out = req_data (word) or the merged word; resp_valid=1 → IDLE.
- ERROR: resp_valid=1, resp_error=1, no memory strobe → IDLE.
- mem_address and mem_data_out are 0 in states where they are not used.

## Timing
- Accept at edge N. Responses:
  - Word store: N+1.
  - Load: N+2.
  - Sub-word store: N+3 (read at N+1, write at N+3).
  - Error: N+1.
- Throughput: the next request can be accepted in the cycle after resp_valid.
- req_valid held high across a busy period: no accept until IDLE; the request must stay stable until accepted.
- Reset:
  - Reset high at an edge forces IDLE; the flow reaches IDLE at that edge from any state.
  - Every output is 0 while reset is high, including req_ready.
  - Reset during MERGE/WRITE of a sub-word store aborts the operation: no mem_write is issued, memory is unchanged, and no response is given.
- The memory's registered read address is only refreshed by mem_read. The unit always issues READ before sampling, so no stale data is consumed.

## Structure
- Add to `architecture.vh`: the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state encodings.
- Sub-module `load_store_align` (combinational):
  - Inputs: raw word, offset, size, unsigned, store data.
  - Outputs: extended load value, merged store word, misaligned flag.
- The FSM and request registers stay in load_store_unit.

## Test plan
- Word store 0xDEADBEEF to 0x10: mem_write at N+1, mem_address=4, mem_data_out=0xDEADBEEF, resp_valid at N+1. A following word load from 0x10 returns resp_data=0xDEADBEEF at N+2.
- Memory word 4 = 0x80FF7F01. Expected byte loads:
  - Signed byte from 0x13 → 0xFFFFFF80.
  - Unsigned byte from 0x13 → 0x00000080.
  - Signed byte from 0x11 → 0x0000007F.
  - Signed half from 0x12 → 0xFFFF80FF.
- Word 4 = 0x11223344, half store 0xABCD to 0x12: mem_read at N+1, mem_write at N+3 with 0xABCD3344, resp_valid at N+3 only.
- Misaligned cases:
  - Word load at 0x11 → resp_valid=1, resp_error=1 at N+1, with no mem_read or mem_write.
  - Size 11 at 0x10 → same response.
- Reset asserted in the MERGE cycle of a byte store: no mem_write, outputs 0, word unchanged on readback, req_ready=1 after reset drops.
- req_valid held high for 3 back-to-back loads: accepts spaced 3 cycles apart, resp_valid pulses exactly once per load.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_pkg
//  Description : Shared size encodings, FSM state encodings and widths for the
//                data-memory load/store unit.
//  Revision    : 1.0  initial release
// ============================================================================
package load_store_unit_pkg;

    localparam int c_ADDRESS_SIZE = 8;
    localparam int c_DATA_SIZE    = 32;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        c_ST_IDLE  = 3'd0,
        c_ST_READ  = 3'd1,
        c_ST_MERGE = 3'd2,
        c_ST_WRITE = 3'd3,
        c_ST_ERROR = 3'd4
    } state_t;

endpackage : load_store_unit_pkg
`default_nettype wire

// File: rtl/load_store_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_align
//  Description : Little-endian lane selection, load sign/zero extension,
//                sub-word store merge and misalignment detection.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_align
    import load_store_unit_pkg::*;
#(
    parameter int DATA_SIZE = c_DATA_SIZE
) (
    input  logic [DATA_SIZE-1:0] i_raw_word,
    input  logic [1:0]           i_offset,
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    input  logic [DATA_SIZE-1:0] i_store_data,
    output logic [DATA_SIZE-1:0] o_load_value,
    output logic [DATA_SIZE-1:0] o_store_word,
    output logic                 o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_raw_word[8*i_offset +: 8];
    assign w_half = i_raw_word[16*i_offset[1] +: 16];

    always_comb begin
        o_load_value = '0;
        o_store_word = i_raw_word;
        case (i_size)
            c_SIZE_BYTE: begin
                o_load_value = {{(DATA_SIZE-8){~i_unsigned & w_byte[7]}}, w_byte};
                o_store_word[8*i_offset +: 8] = i_store_data[7:0];
            end
            c_SIZE_HALF: begin
                o_load_value = {{(DATA_SIZE-16){~i_unsigned & w_half[15]}}, w_half};
                o_store_word[16*i_offset[1] +: 16] = i_store_data[15:0];
            end
            c_SIZE_WORD: begin
                o_load_value = i_raw_word;
                o_store_word = i_store_data;
            end
            default: begin
                o_load_value = '0;
                o_store_word = i_raw_word;
            end
        endcase
    end

    assign o_misaligned = ((i_size == c_SIZE_HALF) && i_offset[0])
                       || ((i_size == c_SIZE_WORD) && (i_offset != 2'b00))
                       || (i_size == 2'b11);

endmodule : load_store_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-memory initiator: byte/half/word loads and stores over a
//                word-addressed memory, read-modify-write for sub-word stores.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDRESS_SIZE = c_ADDRESS_SIZE,
    parameter int DATA_SIZE    = c_DATA_SIZE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDRESS_SIZE+1:0] req_address,
    input  logic [DATA_SIZE-1:0]    req_data,
    output logic                    resp_valid,
    output logic                    resp_error,
    output logic [DATA_SIZE-1:0]    resp_data,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [DATA_SIZE-1:0]    mem_data_out,
    input  logic [DATA_SIZE-1:0]    mem_data_in
);

    state_t                  r_state;
    logic [ADDRESS_SIZE+1:0] r_address;
    logic [1:0]              r_size;
    logic                    r_write;
    logic                    r_unsigned;
    logic [DATA_SIZE-1:0]    r_data;

    logic                    w_idle;
    logic [1:0]              w_offset;
    logic [1:0]              w_size;
    logic [DATA_SIZE-1:0]    w_load_value;
    logic [DATA_SIZE-1:0]    w_store_word;
    logic                    w_misaligned;
    logic                    w_load_done;

    // The aligner checks the live request while idle and the held one otherwise.
    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_offset = w_idle ? req_address[1:0] : r_address[1:0];
    assign w_size   = w_idle ? req_size         : r_size;

    load_store_align #(
        .DATA_SIZE (DATA_SIZE)
    ) u_align (
        .i_raw_word   (mem_data_in),
        .i_offset     (w_offset),
        .i_size       (w_size),
        .i_unsigned   (r_unsigned),
        .i_store_data (r_data),
        .o_load_value (w_load_value),
        .o_store_word (w_store_word),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_address  <= '0;
            r_size     <= '0;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_data     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_address  <= req_address;
                        r_size     <= req_size;
                        r_write    <= req_write;
                        r_unsigned <= req_unsigned;
                        r_data     <= req_data;
                        if (w_misaligned)
                            r_state <= c_ST_ERROR;
                        else if (req_write && (req_size == c_SIZE_WORD))
                            r_state <= c_ST_WRITE;
                        else
                            r_state <= c_ST_READ;
                    end
                end
                c_ST_READ:  r_state <= c_ST_MERGE;
                c_ST_MERGE: begin
                    if (r_write) begin
                        r_data  <= w_store_word;
                        r_state <= c_ST_WRITE;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                c_ST_WRITE: r_state <= c_ST_IDLE;
                c_ST_ERROR: r_state <= c_ST_IDLE;
                default:    r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Every output is forced low while reset is asserted, whatever the state.
    assign w_load_done  = !reset && (r_state == c_ST_MERGE) && !r_write;
    assign req_ready    = !reset && w_idle;
    assign mem_read     = !reset && (r_state == c_ST_READ);
    assign mem_write    = !reset && (r_state == c_ST_WRITE);
    assign mem_address  = (mem_read || mem_write) ? r_address[ADDRESS_SIZE+1:2] : '0;
    assign mem_data_out = mem_write ? r_data : '0;
    assign resp_error   = !reset && (r_state == c_ST_ERROR);
    assign resp_valid   = w_load_done || mem_write || resp_error;
    assign resp_data    = w_load_done ? w_load_value : '0;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit with a
//                one-cycle-latency word memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int AS = 8;
    localparam int DS = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AS+1:0] req_address;
    logic [DS-1:0] req_data;
    logic          resp_valid;
    logic          resp_error;
    logic [DS-1:0] resp_data;
    logic          mem_read;
    logic          mem_write;
    logic [AS-1:0] mem_address;
    logic [DS-1:0] mem_data_out;
    logic [DS-1:0] mem_data_in;

    logic [DS-1:0] mem_model [0:(1<<AS)-1];
    logic [DS-1:0] r_rd_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    load_store_unit #(
        .ADDRESS_SIZE (AS),
        .DATA_SIZE    (DS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_address  (req_address),
        .req_data     (req_data),
        .resp_valid   (resp_valid),
        .resp_error   (resp_error),
        .resp_data    (resp_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in)
    );

    // Word memory: read address registered only on mem_read, data next cycle.
    always @(posedge clock) begin
        if (mem_write) mem_model[mem_address] <= mem_data_out;
        if (mem_read)  r_rd_data <= mem_model[mem_address];
    end
    assign mem_data_in = r_rd_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [AS+1:0] a, input logic [DS-1:0] d);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_address  = a;
        req_data     = d;
    endtask

    task automatic store_word(input logic [AS+1:0] a, input logic [DS-1:0] d, input string tag);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        drive(1'b1, c_SIZE_WORD, 1'b0, a, d);
        tick;
        req_valid = 1'b0;
        chk({tag, " mem_write"}, 32'(mem_write), 32'd1);
        chk({tag, " mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, " addr"}, 32'(mem_address), 32'(a[AS+1:2]));
        chk({tag, " wdata"}, mem_data_out, d);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " resp_error"}, 32'(resp_error), 32'd0);
        tick;
        chk({tag, " resp_off"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic load(input logic [1:0] sz, input logic u, input logic [AS+1:0] a,
                        input logic [DS-1:0] exp, input string tag);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        drive(1'b0, sz, u, a, 32'h0);
        tick;
        req_valid = 1'b0;
        chk({tag, " mem_read"}, 32'(mem_read), 32'd1);
        chk({tag, " mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, " addr"}, 32'(mem_address), 32'(a[AS+1:2]));
        chk({tag, " early_resp"}, 32'(resp_valid), 32'd0);
        tick;
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " resp_error"}, 32'(resp_error), 32'd0);
        chk({tag, " resp_data"}, resp_data, exp);
        tick;
        chk({tag, " resp_off"}, 32'(resp_valid), 32'd0);
        chk({tag, " data_off"}, resp_data, 32'h0);
    endtask

    task automatic store_sub(input logic [1:0] sz, input logic [AS+1:0] a,
                             input logic [DS-1:0] d, input logic [DS-1:0] exp_word, input string tag);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
        drive(1'b1, sz, 1'b0, a, d);
        tick;
        req_valid = 1'b0;
        chk({tag, " n1 mem_read"}, 32'(mem_read), 32'd1);
        chk({tag, " n1 mem_write"}, 32'(mem_write), 32'd0);
        chk({tag, " n1 resp"}, 32'(resp_valid), 32'd0);
        tick;
        chk({tag, " n2 strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({tag, " n2 resp"}, 32'(resp_valid), 32'd0);
        tick;
        chk({tag, " n3 mem_write"}, 32'(mem_write), 32'd1);
        chk({tag, " n3 addr"}, 32'(mem_address), 32'(a[AS+1:2]));
        chk({tag, " n3 wdata"}, mem_data_out, exp_word);
        chk({tag, " n3 resp"}, 32'(resp_valid), 32'd1);
        tick;
        chk({tag, " resp_off"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic bad_req(input logic w, input logic [1:0] sz, input logic [AS+1:0] a, input string tag);
        drive(w, sz, 1'b0, a, 32'h1234_5678);
        tick;
        req_valid = 1'b0;
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, " resp_error"}, 32'(resp_error), 32'd1);
        chk({tag, " strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
        chk({tag, " resp_data"}, resp_data, 32'h0);
        tick;
        chk({tag, " resp_off"}, 32'(resp_valid), 32'd0);
        chk({tag, " ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin : stimulus
        logic [DS-1:0] exp_data [3];
        logic [AS+1:0] addrs [3];
        int acc_cyc [3];
        int n_acc;
        int n_resp;
        logic w_acc;

        reset = 1'b1;
        drive(1'b0, c_SIZE_WORD, 1'b0, '0, '0);
        req_valid = 1'b0;
        tick;
        tick;
        chk("reset ready", 32'(req_ready), 32'd0);
        chk("reset strobes", {29'd0, mem_read, mem_write, resp_valid}, 32'd0);
        chk("reset resp_data", resp_data, 32'h0);
        reset = 1'b0;
        #1;
        chk("post-reset ready", 32'(req_ready), 32'd1);

        store_word(10'h10, 32'hDEAD_BEEF, "sw10");
        load(c_SIZE_WORD, 1'b0, 10'h10, 32'hDEAD_BEEF, "lw10");

        store_word(10'h10, 32'h80FF_7F01, "sw_pat");
        load(c_SIZE_BYTE, 1'b0, 10'h13, 32'hFFFF_FF80, "lb13");
        load(c_SIZE_BYTE, 1'b1, 10'h13, 32'h0000_0080, "lbu13");
        load(c_SIZE_BYTE, 1'b0, 10'h11, 32'h0000_007F, "lb11");
        load(c_SIZE_HALF, 1'b0, 10'h12, 32'hFFFF_80FF, "lh12");
        load(c_SIZE_HALF, 1'b1, 10'h10, 32'h0000_7F01, "lhu10");
        load(c_SIZE_BYTE, 1'b1, 10'h12, 32'h0000_00FF, "lbu12");

        store_word(10'h10, 32'h1122_3344, "sw_rmw");
        store_sub(c_SIZE_HALF, 10'h12, 32'h0000_ABCD, 32'hABCD_3344, "sh12");
        load(c_SIZE_WORD, 1'b0, 10'h10, 32'hABCD_3344, "lw_sh");
        store_sub(c_SIZE_BYTE, 10'h11, 32'hFFFF_FF5A, 32'hABCD_5A44, "sb11");
        load(c_SIZE_WORD, 1'b0, 10'h10, 32'hABCD_5A44, "lw_sb");

        bad_req(1'b0, c_SIZE_WORD, 10'h11, "lw11_misaligned");
        bad_req(1'b0, 2'b11, 10'h10, "size11");
        bad_req(1'b1, c_SIZE_HALF, 10'h13, "sh13_misaligned");

        // Reset lands in the MERGE cycle of a byte store.
        drive(1'b1, c_SIZE_BYTE, 1'b0, 10'h10, 32'h0000_0099);
        tick;
        req_valid = 1'b0;
        chk("rst_sb read", 32'(mem_read), 32'd1);
        tick;
        reset = 1'b1;
        #1;
        chk("rst_sb ready", 32'(req_ready), 32'd0);
        chk("rst_sb outs", {29'd0, mem_read, mem_write, resp_valid}, 32'd0);
        chk("rst_sb error", 32'(resp_error), 32'd0);
        chk("rst_sb addr", 32'(mem_address), 32'd0);
        chk("rst_sb wdata", mem_data_out, 32'h0);
        tick;
        reset = 1'b0;
        #1;
        chk("rst_sb no write", 32'(mem_write), 32'd0);
        chk("rst_sb ready after", 32'(req_ready), 32'd1);
        tick;
        chk("rst_sb still idle", {30'd0, mem_write, resp_valid}, 32'd0);
        chk("rst_sb memory", mem_model[4], 32'hABCD_5A44);
        load(c_SIZE_WORD, 1'b0, 10'h10, 32'hABCD_5A44, "lw_rst");

        store_word(10'h14, 32'h0BAD_F00D, "sw14");
        store_word(10'h18, 32'hCAFE_BABE, "sw18");

        // Three loads with req_valid held high throughout.
        addrs[0] = 10'h10; exp_data[0] = 32'hABCD_5A44;
        addrs[1] = 10'h14; exp_data[1] = 32'h0BAD_F00D;
        addrs[2] = 10'h18; exp_data[2] = 32'hCAFE_BABE;
        acc_cyc[0] = -1; acc_cyc[1] = -1; acc_cyc[2] = -1;
        n_acc  = 0;
        n_resp = 0;
        drive(1'b0, c_SIZE_WORD, 1'b0, addrs[0], 32'h0);
        for (int c = 0; c < 12; c++) begin
            if (resp_valid) begin
                if (n_resp < 3) chk("b2b resp_data", resp_data, exp_data[n_resp]);
                n_resp++;
            end
            w_acc = req_valid && req_ready;
            if (w_acc && n_acc < 3) acc_cyc[n_acc] = c;
            tick;
            if (w_acc) begin
                n_acc++;
                if (n_acc < 3) req_address = addrs[n_acc];
                else           req_valid = 1'b0;
            end
        end
        chk("b2b accepts", 32'(n_acc), 32'd3);
        chk("b2b spacing1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        chk("b2b spacing2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        chk("b2b responses", 32'(n_resp), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire
